// File: rtl/dispatch_tag_scheduler_pkg.sv
// Shared types and constants for the dispatch tag scheduler.
// Tag width, pool size and the instruction-class encodings used by the routing logic.
package dispatch_tag_scheduler_pkg;

  localparam int TAG_W    = 6;
  localparam int NUM_TAGS = 64;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   count_t;

  typedef enum logic [1:0] {
    CLS_INT  = 2'b00,
    CLS_LDST = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_DIV  = 2'b11
  } instr_class_e;

endpackage

// File: rtl/dispatch_tag_scheduler_if.sv
// Front-end / issue-queue / CDB bundle of the dispatch tag scheduler.
// The master drives instructions, queue-full flags and CDB frees; the slave (scheduler) answers.
interface dispatch_tag_scheduler_if;
  import dispatch_tag_scheduler_pkg::*;

  logic         instr_valid;
  instr_class_e instr_class;
  logic         instr_ready;
  logic         issueque_full_integer;
  logic         issueque_full_ld_st;
  logic         issueque_full_mul;
  logic         issueque_full_div;
  logic         dispatch_en_integer;
  logic         dispatch_en_ld_st;
  logic         dispatch_en_mul;
  logic         dispatch_en_div;
  tag_t         dispatch_rd_tag;
  logic         CDB_valid;
  tag_t         CDB_tag;
  count_t       free_count;
  logic         tag_err;

  modport master (
    output instr_valid, instr_class,
    output issueque_full_integer, issueque_full_ld_st, issueque_full_mul, issueque_full_div,
    output CDB_valid, CDB_tag,
    input  instr_ready, dispatch_rd_tag, free_count, tag_err,
    input  dispatch_en_integer, dispatch_en_ld_st, dispatch_en_mul, dispatch_en_div
  );

  modport slave (
    input  instr_valid, instr_class,
    input  issueque_full_integer, issueque_full_ld_st, issueque_full_mul, issueque_full_div,
    input  CDB_valid, CDB_tag,
    output instr_ready, dispatch_rd_tag, free_count, tag_err,
    output dispatch_en_integer, dispatch_en_ld_st, dispatch_en_mul, dispatch_en_div
  );

endinterface

// File: rtl/dispatch_tag_scheduler_tag_free_list.sv
// Circular FIFO of free physical tags, refilled with 0..NUM_TAGS-1 on reset.
// Define DISPATCH_TAG_FREE_CHECK_EN to track busy tags and flag double frees on o_tag_err.
module tag_free_list
  import dispatch_tag_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_pop,
  input  logic   i_push,
  input  tag_t   i_push_tag,
  output tag_t   o_head_tag,
  output count_t o_count,
  output logic   o_tag_err
);

  tag_t   r_ram [NUM_TAGS];
  tag_t   r_rd_ptr;
  tag_t   r_wr_ptr;
  count_t r_count;

  logic w_pop;
  logic w_room;
  logic w_push;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_room = (r_count != count_t'(NUM_TAGS));

`ifdef DISPATCH_TAG_FREE_CHECK_EN
  logic [NUM_TAGS-1:0] r_busy;
  logic                r_tag_err;
  logic                w_bad_free;

  // A free of a tag nobody holds is dropped entirely and latched as an error.
  assign w_bad_free = i_push && !r_busy[i_push_tag];
  assign w_push     = i_push && w_room && r_busy[i_push_tag];
  assign o_tag_err  = r_tag_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_pop)      r_busy[o_head_tag] <= 1'b1;
      if (w_push)     r_busy[i_push_tag] <= 1'b0;
      if (w_bad_free) r_tag_err          <= 1'b1;
    end
  end
`else
  assign w_push    = i_push && w_room;
  assign o_tag_err = 1'b0;
`endif

  // NOTE: the RAM is reset on purpose (the pool must start holding 0..N-1),
  // so it is built from flops rather than a reset-less memory macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) r_ram[i] <= tag_t'(i);
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= count_t'(NUM_TAGS);
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // pre-edge values, so pointer, RAM and count stay mutually consistent.
      if (w_push) begin
        r_ram[r_wr_ptr] <= i_push_tag;
        r_wr_ptr        <= r_wr_ptr + tag_t'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + tag_t'(1);
      case ({w_pop, w_push})
        2'b10:   r_count <= r_count - count_t'(1);
        2'b01:   r_count <= r_count + count_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_tag = r_ram[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/dispatch_tag_scheduler.sv
// Dispatch tag scheduler: routes each accepted instruction to one issue queue and hands it a free tag.
// Optional double-free checking is enabled with DISPATCH_TAG_FREE_CHECK_EN.
module dispatch_tag_scheduler
  import dispatch_tag_scheduler_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  dispatch_tag_scheduler_if.slave bus
);

  logic   w_sel_full;
  logic   w_accept;
  tag_t   w_head_tag;
  count_t w_count;
  logic   w_tag_err;

  // NOTE: assigning a default before the case keeps this purely combinational
  // (no latch) even if the case were ever made incomplete.
  always_comb begin
    w_sel_full = 1'b0;
    case (bus.instr_class)
      CLS_INT:  w_sel_full = bus.issueque_full_integer;
      CLS_LDST: w_sel_full = bus.issueque_full_ld_st;
      CLS_MUL:  w_sel_full = bus.issueque_full_mul;
      CLS_DIV:  w_sel_full = bus.issueque_full_div;
      default:  w_sel_full = 1'b1;
    endcase
  end

  assign bus.instr_ready = (w_count != '0) && !w_sel_full;

  // Nothing is handed out while the pool is being refilled.
  assign w_accept = bus.instr_valid && bus.instr_ready && !reset;

  assign bus.dispatch_en_integer = w_accept && (bus.instr_class == CLS_INT);
  assign bus.dispatch_en_ld_st   = w_accept && (bus.instr_class == CLS_LDST);
  assign bus.dispatch_en_mul     = w_accept && (bus.instr_class == CLS_MUL);
  assign bus.dispatch_en_div     = w_accept && (bus.instr_class == CLS_DIV);

  assign bus.dispatch_rd_tag = w_head_tag;
  assign bus.free_count      = w_count;
  assign bus.tag_err         = w_tag_err;

  tag_free_list u_free_list (
    .clk        (clk),
    .reset      (reset),
    .i_pop      (w_accept),
    .i_push     (bus.CDB_valid),
    .i_push_tag (bus.CDB_tag),
    .o_head_tag (w_head_tag),
    .o_count    (w_count),
    .o_tag_err  (w_tag_err)
  );

endmodule

// File: tb/tb_dispatch_tag_scheduler.sv
// Self-checking bench for dispatch_tag_scheduler: a free-list model feeds a scoreboard of expected tags.
// Compile with DISPATCH_TAG_FREE_CHECK_EN to also exercise double-free detection.
module tb_dispatch_tag_scheduler;
  import dispatch_tag_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dispatch_tag_scheduler_if bus ();

  dispatch_tag_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  tag_t mfree[$];
  tag_t exp_q[$];
  tag_t inflight[$];
  bit   mbusy[NUM_TAGS];
  bit   merr;
  logic [3:0] full_r;

  task automatic set_full(input logic [3:0] f);
    full_r                    = f;
    bus.issueque_full_integer = f[0];
    bus.issueque_full_ld_st   = f[1];
    bus.issueque_full_mul     = f[2];
    bus.issueque_full_div     = f[3];
  endtask

  task automatic model_reset();
    mfree.delete();
    exp_q.delete();
    inflight.delete();
    for (int i = 0; i < NUM_TAGS; i++) begin
      mfree.push_back(tag_t'(i));
      mbusy[i] = 1'b0;
    end
    merr = 1'b0;
  endtask

  task automatic model_free(input tag_t ctag);
`ifdef DISPATCH_TAG_FREE_CHECK_EN
    if (!mbusy[ctag]) merr = 1'b1;
    else begin
      mbusy[ctag] = 1'b0;
      mfree.push_back(ctag);
    end
`else
    if (mfree.size() < NUM_TAGS) begin
      mbusy[ctag] = 1'b0;
      mfree.push_back(ctag);
    end
`endif
    for (int i = 0; i < inflight.size(); i++) begin
      if (inflight[i] == ctag) begin
        inflight.delete(i);
        break;
      end
    end
  endtask

  task automatic check_count(input string name, input int exp);
    total++;
    if (bus.free_count !== count_t'(exp)) begin
      bad++;
      $display("FAIL %s free_count got=%0d exp=%0d", name, bus.free_count, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, update model after the edge.
  task automatic step(input bit valid, input logic [1:0] cls, input bit cdb, input tag_t ctag);
    bit         exp_rdy, exp_acc, have_head;
    logic [3:0] exp_en, got_en;
    tag_t       t, head;
    bus.instr_valid = valid;
    bus.instr_class = instr_class_e'(cls);
    bus.CDB_valid   = cdb;
    bus.CDB_tag     = ctag;
    have_head = (mfree.size() != 0);
    head      = have_head ? mfree[0] : '0;
    exp_rdy   = have_head && !full_r[cls];
    exp_acc   = valid && exp_rdy;
    if (exp_acc) begin
      t = mfree.pop_front();
      exp_q.push_back(t);
      mbusy[t] = 1'b1;
      inflight.push_back(t);
    end
    exp_en = exp_acc ? (4'b0001 << cls) : 4'b0000;
    @(negedge clk);
    total++;
    if (bus.instr_ready !== exp_rdy) begin
      bad++;
      $display("FAIL instr_ready cls=%0d got=%b exp=%b", cls, bus.instr_ready, exp_rdy);
    end
    got_en = {bus.dispatch_en_div, bus.dispatch_en_mul, bus.dispatch_en_ld_st, bus.dispatch_en_integer};
    total++;
    if (got_en !== exp_en) begin
      bad++;
      $display("FAIL dispatch_en cls=%0d got=%b exp=%b", cls, got_en, exp_en);
    end
    if (got_en != 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dispatch_rd_tag unexpected dispatch got=%0d exp=none", bus.dispatch_rd_tag);
      end else begin
        t = exp_q.pop_front();
        if (bus.dispatch_rd_tag !== t) begin
          bad++;
          $display("FAIL dispatch_rd_tag got=%0d exp=%0d", bus.dispatch_rd_tag, t);
        end
      end
    end else begin
      exp_q.delete();
      if (have_head) begin
        total++;
        if (bus.dispatch_rd_tag !== head) begin
          bad++;
          $display("FAIL head_tag got=%0d exp=%0d", bus.dispatch_rd_tag, head);
        end
      end
    end
    @(posedge clk);
    #1;
    if (cdb) model_free(ctag);
    check_count("step", mfree.size());
    total++;
    if (bus.tag_err !== merr) begin
      bad++;
      $display("FAIL tag_err got=%b exp=%b", bus.tag_err, merr);
    end
  endtask

  task automatic do_reset();
    logic [3:0] got_en;
    reset           = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_class = CLS_INT;
    bus.CDB_valid   = 1'b0;
    bus.CDB_tag     = '0;
    set_full(4'b0000);
    @(negedge clk);
    got_en = {bus.dispatch_en_div, bus.dispatch_en_mul, bus.dispatch_en_ld_st, bus.dispatch_en_integer};
    total++;
    if (got_en !== 4'b0000) begin
      bad++;
      $display("FAIL reset_dispatch_en got=%b exp=0000", got_en);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_count("reset", NUM_TAGS);
    total++;
    if (bus.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_tag_err got=%b exp=0", bus.tag_err);
    end
    total++;
    if (bus.dispatch_rd_tag !== tag_t'(0)) begin
      bad++;
      $display("FAIL reset_head got=%0d exp=0", bus.dispatch_rd_tag);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_int_dispatch();
    for (int i = 0; i < 3; i++) step(1'b1, CLS_INT, 1'b0, '0);
    check_count("int_dispatch", 61);
  endtask

  task automatic test_full_backpressure();
    set_full(4'b0100);
    step(1'b1, CLS_MUL, 1'b0, '0);
    total++;
    if (bus.dispatch_rd_tag !== tag_t'(3)) begin
      bad++;
      $display("FAIL mul_full_head got=%0d exp=3", bus.dispatch_rd_tag);
    end
    step(1'b1, CLS_INT, 1'b0, '0);
    set_full(4'b1011);
    step(1'b1, CLS_LDST, 1'b0, '0);
    step(1'b1, CLS_DIV, 1'b0, '0);
    step(1'b1, CLS_INT, 1'b0, '0);
    step(1'b1, CLS_MUL, 1'b0, '0);
    set_full(4'b0000);
    step(1'b1, CLS_MUL, 1'b0, '0);
    step(1'b0, CLS_DIV, 1'b0, '0);
    step(1'b1, CLS_DIV, 1'b0, '0);
    step(1'b1, CLS_LDST, 1'b0, '0);
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < NUM_TAGS; i++) step(1'b1, 2'(i % 4), 1'b0, '0);
    check_count("exhaust", 0);
    step(1'b1, CLS_INT, 1'b1, tag_t'(5));
    step(1'b1, CLS_INT, 1'b0, '0);
    check_count("exhaust_after", 0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 54; i++) step(1'b1, CLS_LDST, 1'b0, '0);
    check_count("simul_pre", 10);
    step(1'b1, CLS_INT, 1'b1, tag_t'(7));
    check_count("simul_same", 10);
    for (int i = 0; i < 11; i++) step(1'b1, CLS_MUL, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 44; i++) step(1'b1, CLS_DIV, 1'b0, '0);
    check_count("mid_pre", 20);
    do_reset();
    step(1'b1, CLS_INT, 1'b0, '0);
  endtask

  task automatic test_overfree();
    do_reset();
    step(1'b0, CLS_INT, 1'b1, tag_t'(9));
    check_count("overfree", NUM_TAGS);
    step(1'b1, CLS_INT, 1'b0, '0);
    step(1'b1, CLS_INT, 1'b0, '0);
  endtask

`ifdef DISPATCH_TAG_FREE_CHECK_EN
  task automatic test_double_free();
    do_reset();
    step(1'b1, CLS_INT, 1'b0, '0);
    step(1'b1, CLS_INT, 1'b0, '0);
    step(1'b0, CLS_INT, 1'b1, tag_t'(40));
    check_count("double_free", 62);
    total++;
    if (bus.tag_err !== 1'b1) begin
      bad++;
      $display("FAIL double_free_err got=%b exp=1", bus.tag_err);
    end
    step(1'b0, CLS_INT, 1'b0, '0);
    step(1'b0, CLS_INT, 1'b1, tag_t'(1));
    total++;
    if (bus.tag_err !== 1'b1) begin
      bad++;
      $display("FAIL sticky_err got=%b exp=1", bus.tag_err);
    end
    do_reset();
  endtask
`endif

  task automatic test_random();
    bit   cdb;
    tag_t ctag;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_full({($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0});
      cdb  = (inflight.size() != 0) && (($urandom % 3) == 0);
      ctag = cdb ? inflight[$urandom_range(0, inflight.size() - 1)] : '0;
      step(($urandom % 4) != 0, 2'($urandom % 4), cdb, ctag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_int_dispatch();
    test_full_backpressure();
    test_exhaust();
    test_simultaneous();
    test_reset_mid();
    test_overfree();
`ifdef DISPATCH_TAG_FREE_CHECK_EN
    test_double_free();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
